// File: rtl/alu_regfile.sv
// alu_regfile: two-read/one-write register file with x0 hardwired to zero, plus an independent combinational ALU
module alu_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      aluop,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
    if (rst) regs_d = '{default: '0};
    regs_d[0] = '0;
  end
  always_ff @(posedge clk) regs_q <= regs_d;
  assign rdata1 = raddr1 == '0 ? '0 : regs_q[raddr1];
  assign rdata2 = raddr2 == '0 ? '0 : regs_q[raddr2];
  // aluop[1] selects the unsigned compare regardless of aluop[0]
  assign result = aluop[1] ? {{(XLEN-1){1'b0}}, src1 < src2} : aluop[0] ? src1 + src2 : '0;
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed register-file and ALU vectors checked with immediate assertions
module tb_alu_regfile;
  logic        clk = 0;
  logic        rst = 1;
  logic [4:0]  raddr1 = 0, raddr2 = 0, waddr = 0;
  logic        we = 0;
  logic [63:0] wdata = 0, src1 = 0, src2 = 0;
  logic [1:0]  aluop = 0;
  logic [63:0] rdata1, rdata2, result;
  int n_tests = 0, n_fail = 0;

  alu_regfile dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .rdata1(rdata1),
    .raddr2(raddr2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .src1(src1), .src2(src2), .aluop(aluop), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    aluop = op; src1 = a; src2 = b;
    #1;
  endtask

  initial begin
    rst = 1;
    alu(2'b01, 64'd2, 64'd3);
    check("alu_during_reset", result, 64'd5);
    tick();
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      check("reset_rd1", rdata1, 64'h0);
      check("reset_rd2", rdata2, 64'h0);
    end
    we = 1; waddr = 5; wdata = 64'hDEADBEEF_00000001; raddr1 = 5; raddr2 = 5;
    #1;
    check("no_bypass_rd1", rdata1, 64'h0);
    tick();
    we = 0;
    #1;
    check("x5_rd1", rdata1, 64'hDEADBEEF_00000001);
    check("x5_rd2", rdata2, 64'hDEADBEEF_00000001);
    we = 1; waddr = 0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we = 0; raddr1 = 0;
    #1;
    check("x0_stays_zero", rdata1, 64'h0);
    check("x5_unchanged", rdata2, 64'hDEADBEEF_00000001);
    we = 1; waddr = 31; wdata = 64'h0123_4567_89AB_CDEF;
    tick();
    waddr = 1; wdata = 64'h1111_2222_3333_4444;
    tick();
    waddr = 3; wdata = 64'd9;
    tick();
    we = 0; raddr1 = 1; raddr2 = 31;
    #1;
    check("x1_rd1", rdata1, 64'h1111_2222_3333_4444);
    check("x31_rd2", rdata2, 64'h0123_4567_89AB_CDEF);
    raddr1 = 3; raddr2 = 1;
    #1;
    check("x3_rd1", rdata1, 64'd9);
    check("x1_rd2", rdata2, 64'h1111_2222_3333_4444);
    alu(2'b01, 64'h80000000, 64'hFFFF_FFFF_FFFF_FFFC);
    check("add_wrap", result, 64'h7FFFFFFC);
    alu(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("add_ones", result, 64'hFFFF_FFFF_FFFF_FFFE);
    alu(2'b10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sltu_lt", result, 64'd1);
    alu(2'b10, 64'd5, 64'd5);
    check("sltu_eq", result, 64'd0);
    alu(2'b10, 64'd0, 64'd1);
    check("sltu_0_1", result, 64'd1);
    alu(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("sltu_gt", result, 64'd0);
    alu(2'b11, 64'd3, 64'd7);
    check("op11_lt", result, 64'd1);
    alu(2'b11, 64'd7, 64'd3);
    check("op11_gt", result, 64'd0);
    rst = 1; we = 1; waddr = 3; wdata = 64'd7;
    alu(2'b01, 64'h10, 64'h20);
    check("alu_in_reset", result, 64'h30);
    tick();
    rst = 0; we = 0; raddr1 = 3; raddr2 = 5;
    #1;
    check("rst_drops_write", rdata1, 64'h0);
    check("rst_clears_x5", rdata2, 64'h0);
    raddr1 = 31; raddr2 = 1;
    #1;
    check("rst_clears_x31", rdata1, 64'h0);
    check("rst_clears_x1", rdata2, 64'h0);
    alu(2'b00, 64'hDEAD_BEEF, 64'h1234);
    check("op00_zero", result, 64'h0);
    alu(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("op00_ones", result, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
